// File: rtl/lock_det_pkg.sv
// Shared types and constants for the bang-bang phase-path lock detector.
// State encodings and channel-select width helper.
package lock_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EVAL  = 2'd2
    } state_t;

    localparam int CH_W_MIN = 1;

    function automatic int ch_width(input int n);
        return ($clog2(n) < CH_W_MIN) ? CH_W_MIN : $clog2(n);
    endfunction

endpackage

// File: rtl/lock_det_window_acc.sv
// Early/late/sample window counters with terminal-count detect.
// Synchronous clear has priority over an incoming sample.
module lock_det_window_acc #(
    parameter int WIN_W = 16
) (
    input  logic             ref_clk,
    input  logic             reset_bar,
    input  logic             clear,
    input  logic             sample,
    input  logic             is_early,
    input  logic [WIN_W-1:0] limit,
    output logic [WIN_W-1:0] early_cnt,
    output logic [WIN_W-1:0] late_cnt,
    output logic             last
);

    logic [WIN_W-1:0] sample_cnt;

    always_ff @(posedge ref_clk or negedge reset_bar) begin
        if (!reset_bar) begin
            early_cnt  <= '0;
            late_cnt   <= '0;
            sample_cnt <= '0;
        end else if (clear) begin
            early_cnt  <= '0;
            late_cnt   <= '0;
            sample_cnt <= '0;
        end else if (sample) begin
            sample_cnt <= sample_cnt + WIN_W'(1);
            if (is_early)
                early_cnt <= early_cnt + WIN_W'(1);
            else
                late_cnt <= late_cnt + WIN_W'(1);
        end
    end

    // The sample that reaches the limit is itself counted.
    assign last = sample &&
        (({1'b0, sample_cnt} + (WIN_W+1)'(1)) >= {1'b0, limit});

endmodule

// File: rtl/bbpd_lock_detector.sv
// Multi-channel early/late lock detector for the ADPLL bang-bang path.
// Optional unlock hysteresis: define LOCK_DETECT_HYST_EN.
module bbpd_lock_detector
    import lock_det_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CH_W           = 2,
    parameter int WIN_W          = 16,
    parameter int TOL_W          = 15,
    parameter int LOCK_W         = 4,
    parameter int UNLOCK_WINDOWS = 2
) (
    input  logic              ref_clk,
    input  logic              reset_bar,
    input  logic              enable,
    input  logic [CH_W-1:0]   ch_select,
    input  logic [NUM_CH-1:0] early,
    input  logic [NUM_CH-1:0] sample_valid,
    input  logic [WIN_W-1:0]  count_untill,
    input  logic [TOL_W-1:0]  positive_tol,
    input  logic [TOL_W-1:0]  negative_tol,
    input  logic [LOCK_W-1:0] lock_windows,
    output logic              locked,
    output logic              lock_lost,
    output logic              window_done,
    output logic [WIN_W-1:0]  early_count,
    output logic [WIN_W-1:0]  late_count,
    output logic [WIN_W:0]    balance,
    output logic [1:0]        state
);

`ifdef LOCK_DETECT_HYST_EN
    localparam int UNLOCK_N = (UNLOCK_WINDOWS < 1) ? 1 : UNLOCK_WINDOWS;
`else
    localparam int UNLOCK_N = 1;
`endif
    localparam int BAD_W = $clog2(UNLOCK_WINDOWS + 2);

    state_t            cur, nxt;
    logic [CH_W-1:0]   ch_q;
    logic              ch_ok, sel_valid, sel_early;
    logic              ch_chg, take, acc_clr, last;
    logic [WIN_W-1:0]  win_early, win_late, count_eff;
    logic [LOCK_W-1:0] lock_eff, good_cnt;
    logic [BAD_W-1:0]  bad_cnt;
    logic signed [WIN_W:0] diff, ptol, ntol;
    logic              good, lock_hit, unlock_hit;

    assign ch_ok     = int'(ch_select) < NUM_CH;
    assign sel_valid = ch_ok && sample_valid[ch_select];
    assign sel_early = ch_ok && early[ch_select];
    assign ch_chg    = (cur == ACCUM) && (ch_select != ch_q);
    assign take      = enable && (cur == ACCUM) && !ch_chg && sel_valid;
    assign acc_clr   = !enable || ch_chg || (cur != ACCUM);

    assign count_eff = (count_untill == '0) ? WIN_W'(1) : count_untill;
    assign lock_eff  = (lock_windows == '0) ? LOCK_W'(1) : lock_windows;

    lock_det_window_acc #(
        .WIN_W (WIN_W)
    ) u_acc (
        .ref_clk   (ref_clk),
        .reset_bar (reset_bar),
        .clear     (acc_clr),
        .sample    (take),
        .is_early  (sel_early),
        .limit     (count_eff),
        .early_cnt (win_early),
        .late_cnt  (win_late),
        .last      (last)
    );

    assign diff = $signed({1'b0, win_early}) - $signed({1'b0, win_late});
    assign ptol = $signed((WIN_W+1)'(positive_tol));
    assign ntol = $signed((WIN_W+1)'(negative_tol));
    assign good = (diff <= ptol) && (-diff <= ntol);

    assign lock_hit =
        ({1'b0, good_cnt} + (LOCK_W+1)'(1)) >= {1'b0, lock_eff};
    assign unlock_hit = (int'(bad_cnt) + 1) >= UNLOCK_N;

    always_comb begin
        nxt = cur;
        unique case (cur)
            IDLE:    if (enable) nxt = ACCUM;
            ACCUM:   if (!enable) nxt = IDLE;
                     else if (last) nxt = EVAL;
            EVAL:    nxt = enable ? ACCUM : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge ref_clk or negedge reset_bar) begin
        if (!reset_bar) begin
            cur  <= IDLE;
            ch_q <= '0;
        end else begin
            cur  <= nxt;
            ch_q <= ch_select;
        end
    end

    assign state = cur;

    // Disable and channel change both abandon the lock history.
    always_ff @(posedge ref_clk or negedge reset_bar) begin
        if (!reset_bar) begin
            locked      <= 1'b0;
            lock_lost   <= 1'b0;
            window_done <= 1'b0;
            early_count <= '0;
            late_count  <= '0;
            balance     <= '0;
            good_cnt    <= '0;
            bad_cnt     <= '0;
        end else begin
            lock_lost   <= 1'b0;
            window_done <= 1'b0;
            if (!enable || ch_chg) begin
                good_cnt  <= '0;
                bad_cnt   <= '0;
                locked    <= 1'b0;
                lock_lost <= locked;
            end else if (cur == EVAL) begin
                window_done <= 1'b1;
                early_count <= win_early;
                late_count  <= win_late;
                balance     <= diff;
                if (good) begin
                    bad_cnt <= '0;
                    if (!(&good_cnt))
                        good_cnt <= good_cnt + LOCK_W'(1);
                    if (lock_hit)
                        locked <= 1'b1;
                end else if (locked) begin
                    if (unlock_hit) begin
                        locked    <= 1'b0;
                        lock_lost <= 1'b1;
                        bad_cnt   <= '0;
                        good_cnt  <= '0;
                    end else begin
                        bad_cnt <= bad_cnt + BAD_W'(1);
                    end
                end else begin
                    good_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bbpd_lock_detector.sv
// Scoreboard bench for bbpd_lock_detector: directed windows push expected
// results, a negedge monitor checks them whenever window_done pulses.
module tb_bbpd_lock_detector;

    logic        ref_clk = 1'b0;
    logic        reset_bar, enable;
    logic [1:0]  ch_select;
    logic [3:0]  early, sample_valid;
    logic [15:0] count_untill;
    logic [14:0] positive_tol, negative_tol;
    logic [3:0]  lock_windows;
    logic        locked, lock_lost, window_done;
    logic [15:0] early_count, late_count;
    logic [16:0] balance;
    logic [1:0]  state;

    bbpd_lock_detector dut (
        .ref_clk      (ref_clk),
        .reset_bar    (reset_bar),
        .enable       (enable),
        .ch_select    (ch_select),
        .early        (early),
        .sample_valid (sample_valid),
        .count_untill (count_untill),
        .positive_tol (positive_tol),
        .negative_tol (negative_tol),
        .lock_windows (lock_windows),
        .locked       (locked),
        .lock_lost    (lock_lost),
        .window_done  (window_done),
        .early_count  (early_count),
        .late_count   (late_count),
        .balance      (balance),
        .state        (state)
    );

    always #5 ref_clk = ~ref_clk;

    typedef struct {
        int e;
        int l;
        bit lk;
        bit lost;
    } exp_t;

    exp_t q[$];
    exp_t mx;
    int   tests = 0;
    int   fails = 0;
    int   lost_seen = 0;
    bit   noise = 1'b0;

    task automatic chk(string name, int act, int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    always @(negedge ref_clk) begin
        if (reset_bar === 1'b1 && window_done === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_window", 1, 0);
            end else begin
                mx = q.pop_front();
                chk("win_early", int'(early_count), mx.e);
                chk("win_late", int'(late_count), mx.l);
                chk("win_balance", int'($signed(balance)), mx.e - mx.l);
                chk("win_locked", int'(locked), int'(mx.lk));
                chk("win_lost", int'(lock_lost), int'(mx.lost));
            end
        end
    end

    always @(negedge ref_clk)
        if (reset_bar === 1'b1 && lock_lost === 1'b1)
            lost_seen++;

    task automatic step();
        @(posedge ref_clk);
        #1;
    endtask

    task automatic drive(bit v, bit e);
        sample_valid = v ? (4'b0001 << ch_select) : 4'b0000;
        early = (v && e) ? (4'b0001 << ch_select) : 4'b0000;
        if (noise) begin
            sample_valid = sample_valid | 4'b0001;
            early = early | 4'b0001;
        end
    endtask

    task automatic win(int ne, int nl, bit lk, bit lost);
        int   ei, li;
        bit   e;
        exp_t x;
        x.e = ne;
        x.l = nl;
        x.lk = lk;
        x.lost = lost;
        q.push_back(x);
        ei = 0;
        li = 0;
        while (ei < ne || li < nl) begin
            e = (ei < ne) && (li >= nl || ei <= li);
            if (e) ei++;
            else li++;
            drive(1'b1, e);
            step();
        end
        chk("state_eval", int'(state), 2);
        drive(1'b0, 1'b0);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_bar    = 1'b0;
        enable       = 1'b0;
        ch_select    = 2'd0;
        early        = '0;
        sample_valid = '0;
        count_untill = 16'd8;
        positive_tol = 15'd2;
        negative_tol = 15'd2;
        lock_windows = 4'd3;
        #1;
        chk("rst_locked", int'(locked), 0);
        chk("rst_lost", int'(lock_lost), 0);
        chk("rst_done", int'(window_done), 0);
        chk("rst_early", int'(early_count), 0);
        chk("rst_late", int'(late_count), 0);
        chk("rst_balance", int'(balance), 0);
        chk("rst_state", int'(state), 0);
        repeat (2) step();
        reset_bar = 1'b1;
        step();
        enable = 1'b1;
        step();
        chk("state_accum", int'(state), 1);

        // balanced lock
        win(4, 4, 1'b0, 1'b0);
        win(4, 4, 1'b0, 1'b0);
        win(4, 4, 1'b1, 1'b0);

        // imbalance while locked
`ifdef LOCK_DETECT_HYST_EN
        win(8, 0, 1'b1, 1'b0);
        win(4, 4, 1'b1, 1'b0);
        win(8, 0, 1'b1, 1'b0);
        win(8, 0, 1'b0, 1'b1);
`else
        win(8, 0, 1'b0, 1'b1);
`endif

        // tolerance boundaries and good_cnt clearing
        win(5, 3, 1'b0, 1'b0);
        win(6, 2, 1'b0, 1'b0);
        win(3, 5, 1'b0, 1'b0);
        win(2, 6, 1'b0, 1'b0);
        win(4, 4, 1'b0, 1'b0);
        win(4, 4, 1'b0, 1'b0);
        win(4, 4, 1'b1, 1'b0);

        // channel switch 0 -> 2 after 4 samples
        repeat (4) begin
            drive(1'b1, 1'b1);
            step();
        end
        ch_select = 2'd2;
        noise = 1'b1;
        drive(1'b1, 1'b1);
        step();
        chk("chsw_locked", int'(locked), 0);
        chk("chsw_lost", int'(lock_lost), 1);
        chk("chsw_state", int'(state), 1);
        win(4, 4, 1'b0, 1'b0);
        noise = 1'b0;

        // zero count/lock fields act as one
        count_untill = 16'd0;
        lock_windows = 4'd0;
        win(1, 0, 1'b1, 1'b0);
        win(0, 1, 1'b1, 1'b0);

        // enable low while locked
        enable = 1'b0;
        drive(1'b0, 1'b0);
        step();
        chk("dis_locked", int'(locked), 0);
        chk("dis_lost", int'(lock_lost), 1);
        chk("dis_state", int'(state), 0);
        chk("hold_early", int'(early_count), 0);
        chk("hold_late", int'(late_count), 1);
        chk("hold_balance", int'($signed(balance)), -1);
        step();
        chk("dis_lost_pulse", int'(lock_lost), 0);

        // reset in the middle of a window
        enable = 1'b1;
        count_untill = 16'd8;
        lock_windows = 4'd3;
        step();
        repeat (3) begin
            drive(1'b1, 1'b1);
            step();
        end
        reset_bar = 1'b0;
        #1;
        chk("mid_rst_state", int'(state), 0);
        chk("mid_rst_early", int'(early_count), 0);
        chk("mid_rst_late", int'(late_count), 0);
        chk("mid_rst_balance", int'(balance), 0);
        chk("mid_rst_locked", int'(locked), 0);
        drive(1'b0, 1'b0);
        step();
        reset_bar = 1'b1;
        step();
        chk("post_rst_state", int'(state), 1);
        win(4, 4, 1'b0, 1'b0);

        repeat (5) step();
        chk("queue_empty", q.size(), 0);
        chk("lost_total", lost_seen, 3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bbpd_lock_detector.md
Name: bbpd_lock_detector

Overview:
Parametrised multi-channel lock detector for the ADPLL bang-bang phase path. One of NUM_CH early/late sources is selected (TDC choice 1, backup TDC, standalone PFD, spares). Early and late decisions are accumulated over a programmable window of valid samples. Lock is declared after a programmable number of consecutive balanced windows. Sits beside the PFD/TDC choice blocks in the ref_clk domain and feeds scan-readable status.

Parameters:
NUM_CH, 4, number of early/late source channels
CH_W, 2, channel select width, equal to clog2(NUM_CH) with a minimum of 1
WIN_W, 16, window length and early/late counter width
TOL_W, 15, tolerance field width; must be less than or equal to WIN_W
LOCK_W, 4, consecutive-good-window counter width
UNLOCK_WINDOWS, 2, consecutive bad windows needed to drop lock; used only with the optional feature

Ports:
ref_clk  in  1  sole clock; everything is on the rising edge
reset_bar  in  1  asynchronous, active-low reset
enable  in  1  run the detector; low forces IDLE
ch_select  in  CH_W  selects the source channel
early  in  NUM_CH  per-channel decision; 1 = early, 0 = late
sample_valid  in  NUM_CH  per-channel strobe; the decision is valid this cycle
count_untill  in  WIN_W  number of valid samples per window
positive_tol  in  TOL_W  maximum allowed value of (early minus late)
negative_tol  in  TOL_W  maximum allowed value of (late minus early)
lock_windows  in  LOCK_W  consecutive good windows required for lock
locked  out  1  lock status
lock_lost  out  1  one-cycle pulse when locked falls
window_done  out  1  one-cycle pulse when a window is evaluated
early_count  out  WIN_W  early total of the last completed window
late_count  out  WIN_W  late total of the last completed window
balance  out  WIN_W+1  signed, early_count minus late_count
state  out  2  current state: 0 = IDLE, 1 = ACCUM, 2 = EVAL

Behaviour:
- Reset (reset_bar low, asynchronous): all outputs 0, state IDLE, internal counters 0.
- IDLE: moves to ACCUM on the cycle after enable is sampled high.
- ACCUM: each cycle where sample_valid[ch_select] is 1:
  - early[ch_select] = 1 increments the early counter; otherwise the late counter increments.
  - The sample counter increments.
  - When the counter reaches the effective count_untill, the next state is EVAL. That last sample is counted.
- Effective values: count_untill = 0 is treated as 1; lock_windows = 0 is treated as 1.
- EVAL lasts exactly one cycle:
  - window_done = 1.
  - early_count, late_count and balance are registered from the window counters. They hold until the next EVAL.
  - Samples arriving in the EVAL cycle are discarded.
  - Window counters clear; the next state is ACCUM.
- Good window: the condition negative_tol ≥ (late minus early) and (early minus late) ≤ positive_tol, evaluated in WIN_W+1-bit signed arithmetic.
  - On a good window, good_cnt increments, saturating at all-ones.
  - locked is set in the EVAL cycle where good_cnt+1 ≥ lock_windows.
- Bad window: good_cnt clears. If locked is 1, locked clears and lock_lost pulses in that EVAL cycle.
- Latency: locked and window_done are registered outputs. They change on the clock edge that ends the EVAL cycle.
- enable low, sampled in any state: next state is IDLE.
  - Window counters, good_cnt and locked clear.
  - If locked was 1, lock_lost pulses.
  - early_count, late_count and balance hold.
- ch_select change in ACCUM: the window restarts with counters cleared.
  - good_cnt clears and locked clears, with a lock_lost pulse if locked was 1.
  - The sample in the change cycle is discarded.
- ch_select ≥ NUM_CH: no sample is ever valid and the window never completes. locked stays 0.
- Counters cannot overflow because the sample count is at most 2^WIN_W−1.

Optional Feature:
LOCK_DETECT_HYST_EN
- Defined: once locked, a bad window only increments bad_cnt, and a good window clears it. locked drops, with a lock_lost pulse, only when bad_cnt reaches UNLOCK_WINDOWS.
- Defined: bad_cnt clears on reset, on enable low and on a channel change.
- Undefined: a single bad window drops lock, and UNLOCK_WINDOWS is unused.

Decomposition:
- Package lock_det_pkg holds:
  - state encodings IDLE = 2'd0, ACCUM = 2'd1, EVAL = 2'd2;
  - the constant for clog2-based CH_W derivation.
- One sub-module: lock_det_window_acc, the early/late/sample counters with terminal-count detect and synchronous clear.
- The FSM, lock logic and output registers stay in the top level.

Test Plan:
- Reset mid-window: reset_bar pulsed low in ACCUM → every output is 0 immediately. After release with enable high, a fresh window starts.
- Balanced lock: ch 0, count_untill = 8, tolerances 2/2, lock_windows = 3, alternating early/late → balance = 0 and window_done every 9 cycles. locked rises at the third EVAL.
- Imbalance loss: while locked, ch 0 gets 8 early samples → balance = +8 and early_count = 8. locked falls with a single lock_lost pulse (hysteresis macro off).
- Tolerance boundary: 5 early / 3 late with positive_tol = 2 counts as good. 6 early / 2 late (balance +4) is bad and good_cnt clears.
- Channel switch: ch_select changes 0→2 after 4 samples → the window restarts and locked clears. The first window_done comes only after 8 valid ch-2 samples.
- Hysteresis (macro on, UNLOCK_WINDOWS = 2): one bad window then one good window → locked stays 1. Two consecutive bad windows → locked 0.
